ps2_rx_fifo: RTL

Parametrised PS/2 device-to-host receiver with input synchronisers, odd-parity and framing checks, an inactivity watchdog, optional E0/F0 prefix decoding, and a first-word-fall-through output FIFO. It replaces the single-byte `ps2` receiver, which has one `valid` strobe and no buffering, between the keyboard pins and the scan-code consumer. It sits in the `clk` domain (50 MHz nominal).

---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_fifo.sv | 53 +++++
 rtl/ps2_rx_fifo.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path: frame FSM states,
// prefix scan codes and the layout of a FIFO entry.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam int CODE_W       = 8;
    localparam int ENTRY_W      = 10;
    localparam int ENTRY_CODE_LSB = 0;
    localparam int ENTRY_BRK_BIT  = 8;
    localparam int ENTRY_EXT_BIT  = 9;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic ext, input logic brk,
                                                      input logic [CODE_W-1:0] code);
        logic [ENTRY_W-1:0] e;
        e = '0;
        e[ENTRY_EXT_BIT] = ext;
        e[ENTRY_BRK_BIT] = brk;
        e[ENTRY_CODE_LSB +: CODE_W] = code;
        return e;
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is presented combinationally
// and reads as zero while empty so the outputs are clean out of reset.
module ps2_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronisers, frame FSM with parity/stop checks,
// inactivity watchdog, optional E0/F0 prefix folding and a buffered output.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int TIMEOUT_US    = 2000,
    parameter int SYNC_STAGES   = 2,
    parameter int FIFO_DEPTH    = 8,
    parameter int DECODE_PREFIX = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data_in,
    input  logic       rd_en,
    output logic [7:0] ps2_data_out,
    output logic       ext_flag,
    output logic       break_flag,
    output logic       empty,
    output logic       full,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);
    localparam int WD_LIMIT = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int WD_W     = $clog2(WD_LIMIT + 1);

    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_prev_p0, fall_p1, bit_p1;
    ps2_state_t             state, state_n;
    logic [2:0]             bit_cnt, bit_cnt_n;
    logic [CODE_W-1:0]      shreg, shreg_n;
    logic                   par_bit, par_n;
    logic [WD_W-1:0]        wd_cnt;
    logic                   ext_pend, brk_pend;
    logic                   wd_timeout, stop_seen, stop_err, par_fail, accept;
    logic                   is_ext, is_brk, push_req, overflow_c;
    logic [ENTRY_W-1:0]     head;

    // Stage 0: synchronisers; stage 1: registered falling edge with its data bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync    <= '1;
            data_sync   <= '1;
            clk_prev_p0 <= 1'b1;
            fall_p1     <= 1'b0;
            bit_p1      <= 1'b1;
        end else begin
            clk_sync    <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync   <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
            clk_prev_p0 <= clk_sync[SYNC_STAGES-1];
            fall_p1     <= clk_prev_p0 & ~clk_sync[SYNC_STAGES-1];
            bit_p1      <= data_sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        par_n      = par_bit;
        stop_seen  = 1'b0;
        wd_timeout = (state != ST_IDLE) && !fall_p1 && (wd_cnt == WD_W'(WD_LIMIT - 1));
        if (wd_timeout) begin
            state_n = ST_IDLE;
        end else if (fall_p1) begin
            case (state)
                ST_IDLE: begin
                    // A high "start" bit is line noise, not a frame.
                    if (!bit_p1) begin
                        state_n   = ST_DATA;
                        bit_cnt_n = 3'd0;
                    end
                end
                ST_DATA: begin
                    shreg_n   = {bit_p1, shreg[CODE_W-1:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = ST_PARITY;
                end
                ST_PARITY: begin
                    par_n   = bit_p1;
                    state_n = ST_STOP;
                end
                default: begin
                    state_n   = ST_IDLE;
                    stop_seen = 1'b1;
                end
            endcase
        end
    end

    assign stop_err   = stop_seen & ~bit_p1;
    assign par_fail   = stop_seen & bit_p1 & ~(^{shreg, par_bit});
    assign accept     = stop_seen & bit_p1 & (^{shreg, par_bit});
    assign is_ext     = (DECODE_PREFIX != 0) && (shreg == PS2_EXT);
    assign is_brk     = (DECODE_PREFIX != 0) && (shreg == PS2_BRK);
    assign push_req   = accept & ~is_ext & ~is_brk;
    assign overflow_c = push_req & full & ~rd_en;

    // Stage 2: FSM state, watchdog, prefix flags and error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            wd_cnt     <= '0;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            wd_cnt     <= (state == ST_IDLE || fall_p1) ? '0 : wd_cnt + 1'b1;
            parity_err <= par_fail;
            frame_err  <= stop_err | wd_timeout;
            overflow   <= overflow_c;
            if (stop_err || par_fail || wd_timeout) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (accept) begin
                if (is_ext) begin
                    ext_pend <= 1'b1;
                end else if (is_brk) begin
                    brk_pend <= 1'b1;
                end else begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        shreg   <= shreg_n;
        par_bit <= par_n;
    end

    ps2_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (rd_en),
        .din   (pack_entry(ext_pend, brk_pend, shreg)),
        .dout  (head),
        .empty (empty),
        .full  (full)
    );

    assign ps2_data_out = head[ENTRY_CODE_LSB +: CODE_W];
    assign ext_flag     = head[ENTRY_EXT_BIT];
    assign break_flag   = head[ENTRY_BRK_BIT];

endmodule
